// File: rtl/or1k_pic_tt_pkg.sv
// or1k_pic_tt_pkg: SPR decode constants, TTMR field positions and tick timer modes
package or1k_pic_tt_pkg;
  localparam logic [4:0]  SPR_GRP_PIC = 5'd9;
  localparam logic [4:0]  SPR_GRP_TT  = 5'd10;
  localparam logic [10:0] PIC_IDX_MR  = 11'd0;
  localparam logic [10:0] PIC_IDX_SR  = 11'd2;
  localparam logic [10:0] TT_IDX_MR   = 11'd0;
  localparam logic [10:0] TT_IDX_CR   = 11'd1;
  localparam int TTMR_TP_W  = 28;
  localparam int TTMR_IE    = 28;
  localparam int TTMR_IP    = 29;
  localparam int TTMR_M_LSB = 30;
  typedef enum logic [1:0] {
    TT_OFF     = 2'b00,
    TT_RESTART = 2'b01,
    TT_SINGLE  = 2'b10,
    TT_CONT    = 2'b11
  } tt_mode_e;
endpackage

// File: rtl/or1k_pic_tt_irq_edge.sv
// or1k_pic_tt_irq_edge: one-cycle event pulse on each rising edge of a level request
// Ports: clk, rstn (sync, active-low), irq (level in), evt (pulse out)
module or1k_pic_tt_irq_edge (
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  output logic evt
);
  logic irq_q;
  always_ff @(posedge clk) irq_q <= rstn ? irq : 1'b0;
  assign evt = irq & ~irq_q;
endmodule

// File: rtl/or1k_pic_tt.sv
// or1k_pic_tt: OR1K PIC (SPR group 9) and tick timer (SPR group 10) behind one SPR port
// Ports: clk, rstn (sync, active-low); SPR port spr_cs/spr_write/spr_addr/spr_dat_i/spr_dat_o;
//        du_stall freezes the tick counter; pic_int level inputs; pic_intr/pic_wakeup/tt_intr
//        level requests and pic_intr_evt/tt_intr_evt rising-edge pulses.
module or1k_pic_tt
  import or1k_pic_tt_pkg::*;
#(
  parameter int PIC_INTS = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                spr_cs,
  input  logic                spr_write,
  input  logic [31:0]         spr_addr,
  input  logic [31:0]         spr_dat_i,
  output logic [31:0]         spr_dat_o,
  input  logic                du_stall,
  input  logic [PIC_INTS-1:0] pic_int,
  output logic                pic_intr,
  output logic                pic_wakeup,
  output logic                tt_intr,
  output logic                pic_intr_evt,
  output logic                tt_intr_evt
);
  logic [4:0]          grp;
  logic [10:0]         idx;
  logic                wr, sel_picmr, sel_picsr, sel_ttmr, sel_ttcr;
  logic [PIC_INTS-1:2] picmr_hi;
  logic [PIC_INTS-1:0] picmr, picsr, um;
  logic [31:0]         ttmr, ttcr, ttcr_hw;
  tt_mode_e            mode;
  logic                match;
  logic                unused_addr;
  assign grp         = spr_addr[15:11];
  assign idx         = spr_addr[10:0];
  assign unused_addr = ^spr_addr[31:16];
  assign wr          = spr_cs & spr_write;
  assign sel_picmr   = (grp == SPR_GRP_PIC) && (idx == PIC_IDX_MR);
  assign sel_picsr   = (grp == SPR_GRP_PIC) && (idx == PIC_IDX_SR);
  assign sel_ttmr    = (grp == SPR_GRP_TT) && (idx == TT_IDX_MR);
  assign sel_ttcr    = (grp == SPR_GRP_TT) && (idx == TT_IDX_CR);
  // Lines 0 and 1 are non-maskable, so their mask bits are constant ones.
  assign picmr = {picmr_hi, 2'b11};
  assign um    = pic_int & picmr;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      picmr_hi <= '0;
      picsr    <= '0;
    end else begin
      if (wr && sel_picmr) picmr_hi <= spr_dat_i[PIC_INTS-1:2];
      picsr <= ((wr && sel_picsr) ? spr_dat_i[PIC_INTS-1:0] : picsr) | um;
    end
  end
  assign pic_intr   = |(picsr & picmr);
  assign pic_wakeup = pic_intr;
  assign mode  = tt_mode_e'(ttmr[TTMR_M_LSB +: 2]);
  assign match = (ttcr[TTMR_TP_W-1:0] == ttmr[TTMR_TP_W-1:0]) && (mode != TT_OFF);
  // Single-run parks on the match value; restart folds back to zero after the match cycle.
  always_comb
    ttcr_hw = (mode == TT_OFF || du_stall || (match && mode == TT_SINGLE)) ? ttcr :
              (match && mode == TT_RESTART) ? 32'd0 : ttcr + 32'd1;
  // Any software write to the timer suppresses every hardware update that cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ttmr <= '0;
      ttcr <= '0;
    end else if (wr && sel_ttmr) begin
      ttmr <= spr_dat_i;
    end else if (wr && sel_ttcr) begin
      ttcr <= spr_dat_i;
    end else begin
      ttcr <= ttcr_hw;
      if (match && ttmr[TTMR_IE]) ttmr[TTMR_IP] <= 1'b1;
    end
  end
  assign tt_intr = ttmr[TTMR_IP] & ttmr[TTMR_IE];
  always_comb
    spr_dat_o = !spr_cs   ? 32'd0 :
                sel_picmr ? 32'(picmr) :
                sel_picsr ? 32'(picsr) :
                sel_ttmr  ? ttmr :
                sel_ttcr  ? ttcr : 32'd0;
  or1k_pic_tt_irq_edge u_pic_edge (.clk(clk), .rstn(rstn), .irq(pic_intr), .evt(pic_intr_evt));
  or1k_pic_tt_irq_edge u_tt_edge  (.clk(clk), .rstn(rstn), .irq(tt_intr),  .evt(tt_intr_evt));
endmodule

// File: tb/tb_or1k_pic_tt.sv
// tb_or1k_pic_tt: scoreboard bench for or1k_pic_tt against a behavioural model
module tb_or1k_pic_tt;
  localparam int N = 20;
  localparam logic [31:0] A_PICMR = 32'h0000_4800;
  localparam logic [31:0] A_PICSR = 32'h0000_4802;
  localparam logic [31:0] A_TTMR  = 32'h0000_5000;
  localparam logic [31:0] A_TTCR  = 32'h0000_5001;
  logic clk = 0, rstn = 0, spr_cs = 0, spr_write = 0, du_stall = 0;
  logic [31:0] spr_addr = 0, spr_dat_i = 0, spr_dat_o;
  logic [N-1:0] pic_int = 0;
  logic pic_intr, pic_wakeup, tt_intr, pic_intr_evt, tt_intr_evt;
  or1k_pic_tt #(.PIC_INTS(N)) dut (
    .clk(clk), .rstn(rstn), .spr_cs(spr_cs), .spr_write(spr_write), .spr_addr(spr_addr),
    .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o), .du_stall(du_stall), .pic_int(pic_int),
    .pic_intr(pic_intr), .pic_wakeup(pic_wakeup), .tt_intr(tt_intr),
    .pic_intr_evt(pic_intr_evt), .tt_intr_evt(tt_intr_evt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] dat;
    logic pi, ti, pe, te;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  // Behavioural model state, kept as separate fields rather than packed registers.
  logic [N-1:0] m_mask, m_sr;
  logic [27:0]  m_tp;
  bit m_ie, m_ip, m_pq, m_tq, started = 0;
  bit [1:0] m_mode;
  logic [31:0] m_cnt;
  bit nx_rst = 0, nx_stall = 0;
  logic [N-1:0] nx_ints = 0;
  function automatic logic [31:0] m_read(logic [31:0] a);
    int g = int'(a[15:11]), i = int'(a[10:0]);
    if (g == 9 && i == 0) return 32'(m_mask);
    if (g == 9 && i == 2) return 32'(m_sr);
    if (g == 10 && i == 0) return {m_mode, m_ip, m_ie, m_tp};
    if (g == 10 && i == 1) return m_cnt;
    return 0;
  endfunction
  task automatic m_step();
    bit pi, ti, hit, w;
    logic [N-1:0] um;
    int g, i;
    if (!rstn) begin
      m_mask = 3; m_sr = 0; m_tp = 0; m_ie = 0; m_ip = 0; m_mode = 0; m_cnt = 0;
      m_pq = 0; m_tq = 0; started = 1;
      return;
    end
    pi = |(m_sr & m_mask);
    ti = m_ip & m_ie;
    w = spr_cs & spr_write;
    g = int'(spr_addr[15:11]);
    i = int'(spr_addr[10:0]);
    um = pic_int & m_mask;
    m_sr = ((w && g == 9 && i == 2) ? spr_dat_i[N-1:0] : m_sr) | um;
    if (w && g == 9 && i == 0) m_mask = spr_dat_i[N-1:0] | 3;
    hit = m_mode != 0 && m_cnt[27:0] == m_tp;
    if (w && g == 10 && i == 0) begin
      m_mode = spr_dat_i[31:30]; m_ip = spr_dat_i[29]; m_ie = spr_dat_i[28]; m_tp = spr_dat_i[27:0];
    end else if (w && g == 10 && i == 1) begin
      m_cnt = spr_dat_i;
    end else begin
      if (hit && m_ie) m_ip = 1;
      if (m_mode != 0 && !du_stall) begin
        if (hit && m_mode == 1) m_cnt = 0;
        else if (!(hit && m_mode == 2)) m_cnt = m_cnt + 1;
      end
    end
    m_pq = pi;
    m_tq = ti;
  endtask
  task automatic cyc(bit cs, bit we, logic [31:0] a, logic [31:0] d, bit hk, logic [31:0] k);
    exp_t e;
    @(posedge clk);
    m_step();
    #1;
    rstn = nx_rst; spr_cs = cs; spr_write = we; spr_addr = a; spr_dat_i = d;
    pic_int = nx_ints; du_stall = nx_stall;
    if (started && nx_rst) begin
      e.dat = !cs ? 32'd0 : hk ? k : m_read(a);
      e.pi = |(m_sr & m_mask);
      e.ti = m_ip & m_ie;
      e.pe = e.pi & ~m_pq;
      e.te = e.ti & ~m_tq;
      q.push_back(e);
    end
  endtask
  task automatic idle();                             cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic wr(logic [31:0] a, logic [31:0] d); cyc(1, 1, a, d, 0, 0); endtask
  task automatic rdk(logic [31:0] a, logic [31:0] k); cyc(1, 0, a, 0, 1, k); endtask
  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, want, $time);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("spr_dat_o", spr_dat_o, e.dat);
      chk("pic_intr", 32'(pic_intr), 32'(e.pi));
      chk("pic_wakeup", 32'(pic_wakeup), 32'(e.pi));
      chk("tt_intr", 32'(tt_intr), 32'(e.ti));
      chk("pic_intr_evt", 32'(pic_intr_evt), 32'(e.pe));
      chk("tt_intr_evt", 32'(tt_intr_evt), 32'(e.te));
    end
  end
  initial begin
    logic [31:0] a, d;
    repeat (3) idle();
    nx_rst = 1;
    rdk(A_PICMR, 32'h3); rdk(A_PICSR, 0); rdk(A_TTMR, 0); rdk(A_TTCR, 0);
    wr(A_PICMR, 32'h10);
    nx_ints = 20'h10; idle(); nx_ints = 0;
    rdk(A_PICSR, 32'h10); idle();
    wr(A_PICSR, 0); idle(); rdk(A_PICSR, 0);
    nx_ints = 20'h20; idle(); nx_ints = 0;
    rdk(A_PICSR, 0);
    nx_ints = 20'h1; idle(); nx_ints = 0;
    rdk(A_PICSR, 32'h1); wr(A_PICSR, 0); idle();
    wr(A_TTMR, 32'h5000_0004); wr(A_TTCR, 0);
    rdk(A_TTCR, 0); rdk(A_TTCR, 1); rdk(A_TTCR, 2); rdk(A_TTCR, 3); rdk(A_TTCR, 4);
    rdk(A_TTCR, 0); rdk(A_TTCR, 1);
    wr(A_TTMR, 32'h5000_0004); rdk(A_TTMR, 32'h5000_0004);
    wr(A_TTMR, 32'h9000_0003); wr(A_TTCR, 0);
    repeat (3) idle();
    rdk(A_TTCR, 3); rdk(A_TTCR, 3); rdk(A_TTMR, 32'hB000_0003);
    wr(A_TTMR, 32'h9000_0003); wr(A_TTCR, 100);
    rdk(A_TTCR, 100); rdk(A_TTMR, 32'h9000_0003);
    wr(A_TTMR, 32'hC000_0FFF); wr(A_TTCR, 50);
    nx_stall = 1; rdk(A_TTCR, 50); rdk(A_TTCR, 50);
    nx_stall = 0; rdk(A_TTCR, 50); rdk(A_TTCR, 51);
    wr(A_TTMR, 32'hD000_0010); wr(A_TTCR, 16);
    nx_stall = 1; rdk(A_TTCR, 16); rdk(A_TTMR, 32'hF000_0010); nx_stall = 0;
    nx_ints = 20'h2; wr(A_PICSR, 0); nx_ints = 0;
    rdk(A_PICSR, 32'h2);
    wr(A_TTMR, 32'h0); wr(A_PICSR, 0); idle();
    for (int n = 0; n < 3000; n++) begin
      nx_rst = ($urandom_range(0, 199) != 0);
      nx_stall = ($urandom_range(0, 4) == 0);
      nx_ints = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom & $urandom) : '0;
      case ($urandom_range(0, 5))
        0: a = A_PICMR;
        1: a = A_PICSR;
        2: a = A_TTMR;
        3: a = A_TTCR;
        4: a = $urandom;
        default: a = 32'h0000_4801;
      endcase
      a[31:16] = 16'($urandom);
      d = $urandom;
      if (a[15:0] == A_TTMR[15:0]) d = {d[31:28], 24'd0, d[3:0]};
      if (a[15:0] == A_TTCR[15:0]) d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        0: wr(a, d);
        1: cyc(1, 0, a, d, 0, 0);
        default: idle();
      endcase
    end
    nx_rst = 1;
    idle(); idle();
    @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
